// File: rtl/wb_trace_fifo.sv
// First-word-fall-through buffer for the write-back trace stream.
// Captures real register-file writes and counts the commits it had to drop while full.
module wb_trace_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   debug_wb_pc,
    input  logic [3:0]    debug_wb_rf_wen,
    input  logic [4:0]    debug_wb_rf_wnum,
    input  logic [31:0]   debug_wb_rf_wdata,
    input  logic          clear,
    output logic          trace_valid,
    input  logic          trace_ready,
    output logic [31:0]   trace_pc,
    output logic [3:0]    trace_wen,
    output logic [4:0]    trace_wnum,
    output logic [31:0]   trace_wdata,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic [15:0]   drop_cnt
);

    localparam int unsigned EW        = 73;
    localparam logic [AW:0] LevelFull = (AW + 1)'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;

    logic          cap;
    logic          pop;
    logic          push;
    logic          drop;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head;

    always_comb begin
        cap      = (debug_wb_rf_wen != 4'b0) && (debug_wb_rf_wnum != 5'd0);
        pop      = (level_q != '0) && trace_ready;
        // A full FIFO still accepts a commit when the head leaves in the same cycle.
        push     = cap && ((level_q != LevelFull) || pop);
        drop     = cap && !push;
        wr_entry = {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata};
    end

    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (clear) begin
            wp_d       = '0;
            rp_d       = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (push) begin
                wp_d = wp_q + AW'(1);
            end
            if (pop) begin
                rp_d = rp_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   level_d = level_q + (AW + 1)'(1);
                2'b01:   level_d = level_q - (AW + 1)'(1);
                default: level_d = level_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q       <= '0;
            rp_q       <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is not reset; valid data is tracked purely by level and the pointers.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wp_q] <= wr_entry;
        end
    end

    always_comb begin
        head        = mem_q[rp_q];
        trace_valid = (level_q != '0);
        trace_pc    = head[72:41];
        trace_wen   = head[40:37];
        trace_wnum  = head[36:32];
        trace_wdata = head[31:0];
        level       = level_q;
        overflow    = overflow_q;
        drop_cnt    = drop_cnt_q;
    end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Bench for wb_trace_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_wb_trace_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   debug_wb_pc;
    logic [3:0]    debug_wb_rf_wen;
    logic [4:0]    debug_wb_rf_wnum;
    logic [31:0]   debug_wb_rf_wdata;
    logic          clear;
    logic          trace_valid;
    logic          trace_ready;
    logic [31:0]   trace_pc;
    logic [3:0]    trace_wen;
    logic [4:0]    trace_wnum;
    logic [31:0]   trace_wdata;
    logic [AW:0]   level;
    logic          overflow;
    logic [15:0]   drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [72:0] mq[$];
    logic        m_ovf;
    int          m_drops;

    wb_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk               (clk),
        .reset             (reset),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .clear             (clear),
        .trace_valid       (trace_valid),
        .trace_ready       (trace_ready),
        .trace_pc          (trace_pc),
        .trace_wen         (trace_wen),
        .trace_wnum        (trace_wnum),
        .trace_wdata       (trace_wdata),
        .level             (level),
        .overflow          (overflow),
        .drop_cnt          (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue, stats follow the capture/drop rules directly.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else if (clear) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            bit c, p, q;
            c = (debug_wb_rf_wen != 0) && (debug_wb_rf_wnum != 0);
            p = (mq.size() != 0) && trace_ready;
            q = c && (mq.size() < DEPTH || p);
            if (p) void'(mq.pop_front());
            if (q) mq.push_back({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum,
                                 debug_wb_rf_wdata});
            if (c && !q) begin
                m_ovf = 1'b1;
                if (m_drops < 65535) m_drops++;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("valid", trace_valid, mq.size() != 0);
            check("level", level, mq.size());
            check("overflow", overflow, m_ovf);
            check("drop_cnt", drop_cnt, m_drops);
            if (mq.size() != 0)
                check("head", {trace_pc, trace_wen, trace_wnum, trace_wdata}, mq[0]);
        end
    end

    task automatic commit(input logic [31:0] pc, input logic [3:0] wen,
                          input logic [4:0] wnum, input logic [31:0] wdata);
        debug_wb_pc       = pc;
        debug_wb_rf_wen   = wen;
        debug_wb_rf_wnum  = wnum;
        debug_wb_rf_wdata = wdata;
        @(negedge clk);
        debug_wb_rf_wen   = 4'h0;
        debug_wb_rf_wnum  = 5'd0;
    endtask

    task automatic drain();
        trace_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && mq.size() != 0; i++) @(negedge clk);
        trace_ready = 1'b0;
        check("drain_empty", trace_valid, 1'b0);
    endtask

    task automatic fill(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++)
            commit(32'h1000 + 32'(4 * i), 4'hF, 5'(1 + i % 31), base + 32'(i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] prev;
        bit          prev_hold;
        int          idx;

        reset = 1'b1;
        clear = 1'b0;
        trace_ready = 1'b0;
        debug_wb_pc = '0;
        debug_wb_rf_wen = '0;
        debug_wb_rf_wnum = '0;
        debug_wb_rf_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", trace_valid, 1'b0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_drop_cnt", drop_cnt, 0);
        reset = 1'b0;
        @(negedge clk);

        // Filter: only the third commit is a real register write.
        commit(32'h1111_0000, 4'hF, 5'd0, 32'hDEAD_0000);
        commit(32'h2222_0000, 4'h0, 5'd5, 32'hDEAD_0001);
        commit(32'hBFC0_0380, 4'h1, 5'd5, 32'h1234_5678);
        check("filter_level", level, 1);
        check("filter_valid", trace_valid, 1'b1);
        check("filter_pc", trace_pc, 32'hBFC0_0380);
        check("filter_wdata", trace_wdata, 32'h1234_5678);
        drain();

        // Fill and drop: 18 commits into 16 slots, oldest data kept.
        fill(18, 32'd0);
        check("fill_level", level, 16);
        check("fill_overflow", overflow, 1'b1);
        check("fill_drop_cnt", drop_cnt, 2);
        trace_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("fill_order", trace_wdata, 32'(i));
            @(negedge clk);
        end
        trace_ready = 1'b0;
        check("fill_empty", trace_valid, 1'b0);

        // Full FIFO with a simultaneous pop accepts the new commit.
        fill(16, 32'd100);
        trace_ready = 1'b1;
        commit(32'hA000_0000, 4'hF, 5'd7, 32'hAA);
        check("fullpop_level", level, 16);
        check("fullpop_drop_cnt", drop_cnt, 2);
        repeat (15) @(negedge clk);
        check("fullpop_16th", trace_wdata, 32'hAA);
        drain();

        // Streaming with pointer wrap.
        trace_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            commit($urandom, 4'hF, 5'(1 + i % 31), $urandom);
            check("stream_level", level <= 1, 1'b1);
        end
        @(negedge clk);
        check("stream_empty", trace_valid, 1'b0);
        check("stream_drops", drop_cnt, 2);
        trace_ready = 1'b0;

        // Backpressure: toggle ready, head must hold while not accepted.
        for (int i = 0; i < 3; i++) commit(32'h3000 + 32'(i), 4'h3, 5'd9, 32'hB0 + 32'(i));
        idx = 0;
        prev_hold = 0;
        prev = '0;
        for (int k = 0; k < 8; k++) begin
            if (prev_hold) check("bp_hold", trace_wdata, prev);
            trace_ready = k[0];
            prev_hold = trace_valid && !trace_ready;
            prev = trace_wdata;
            if (trace_valid && trace_ready) begin
                check("bp_order", trace_wdata, 32'hB0 + 32'(idx));
                idx++;
            end
            @(negedge clk);
        end
        trace_ready = 1'b0;
        check("bp_count", idx, 3);
        check("bp_empty", trace_valid, 1'b0);

        // Clear with 5 entries, 7 drops and a concurrent capture.
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        fill(16 + 7, 32'd200);
        check("clr_pre_drops", drop_cnt, 7);
        trace_ready = 1'b1;
        repeat (11) @(negedge clk);
        trace_ready = 1'b0;
        check("clr_pre_level", level, 5);
        clear = 1'b1;
        commit(32'h4000, 4'hF, 5'd3, 32'hC1EA);
        clear = 1'b0;
        check("clr_level", level, 0);
        check("clr_overflow", overflow, 1'b0);
        check("clr_drop_cnt", drop_cnt, 0);
        check("clr_valid", trace_valid, 1'b0);

        // Randomized traffic with occasional clears.
        for (int k = 0; k < 400; k++) begin
            trace_ready = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 63) == 0);
            debug_wb_pc = $urandom;
            debug_wb_rf_wdata = $urandom;
            debug_wb_rf_wen = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            debug_wb_rf_wnum = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            @(negedge clk);
        end
        clear = 1'b0;
        trace_ready = 1'b0;
        debug_wb_rf_wen = 4'h0;
        debug_wb_rf_wnum = 5'd0;

        // Asynchronous reset mid-cycle empties the FIFO without a clock edge.
        fill(2, 32'd300);
        check("arst_pre_valid", trace_valid, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", trace_valid, 1'b0);
        check("arst_level", level, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("arst_after_valid", trace_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_trace_fifo.md
# wb_trace_fifo

Buffers the core's write-back trace stream so a slower consumer (on-board trace dump or debug link) can drain it without losing commits. Sits directly downstream of the CPU top's trace debug interface. Captures every cycle that performs a real register-file write into a first-word-fall-through FIFO. Presents entries on a valid/ready port and counts and flags any commits dropped on overflow.

## Interface
- DEPTH, 16, number of entries; power of two, ≥ 2.
- AW, 4, log2(DEPTH).
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- debug_wb_pc  in  32  PC of the instruction in WB this cycle.
- debug_wb_rf_wen  in  4  byte write enables of the RF write this cycle.
- debug_wb_rf_wnum  in  5  destination register number.
- debug_wb_rf_wdata  in  32  write data.
- clear  in  1  synchronous flush of contents and statistics.
- trace_valid  out  1  head entry available.
- trace_ready  in  1  consumer accepts head entry this cycle.
- trace_pc  out  32  head entry PC.
- trace_wen  out  4  head entry byte enables.
- trace_wnum  out  5  head entry register number.
- trace_wdata  out  32  head entry data.
- level  out  AW+1  entries currently stored, 0..DEPTH.
- overflow  out  1  sticky; at least one commit dropped since reset/clear.
- drop_cnt  out  16  dropped commits, saturating at 16'hFFFF.

## Operation
- Capture condition: cap = (debug_wb_rf_wen != 4'b0) && (debug_wb_rf_wnum != 5'd0). Writes to $0 and non-writing cycles are never stored.
- Entry = {pc, wen, wnum, wdata}, 73 bits, stored verbatim.
- pop = trace_valid && trace_ready.
- push = cap && (level < DEPTH || pop). Pushing into a full FIFO is legal when a pop occurs in the same cycle.
- drop = cap && !push. On drop:
  - overflow ← 1.
  - drop_cnt ← drop_cnt + 1, held at 16'hFFFF once reached.
  - FIFO contents unchanged; the oldest data is kept.
- Storage: DEPTH×73 register array, write pointer wp and read pointer rp, each AW bits, wrapping modulo DEPTH.
- level register update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Outputs:
  - trace_valid = (level != 0).
  - trace_* fields = mem[rp], combinational from the registered array (FWFT).
  - When trace_valid = 0, trace_* field values are don't-care.
- clear (synchronous): wp, rp, level, overflow and drop_cnt ← 0. clear wins over push, pop and drop in the same cycle; the concurrent capture is discarded and not counted.
- Array contents need no reset.

## Timing
- Reset (async assert, sync-released by the system):
  - trace_valid = 0, level = 0, overflow = 0, drop_cnt = 0.
  - wp = rp = 0.
- Reset mid-operation discards all entries immediately.
- Latency: a commit captured at edge N is visible on trace_* with trace_valid = 1 after edge N (cycle N+1) when the FIFO was empty.
- Throughput: one push and one pop per cycle sustained; level is constant under continuous capture with trace_ready = 1.
- Handshake:
  - trace_* and trace_valid stay stable while trace_valid && !trace_ready.
  - The consumer may hold trace_ready high while trace_valid = 0; no pop occurs.
- Pointer wrap: after DEPTH pushes, wp returns to 0. Full is distinguished from empty by level, not by pointer equality.
- No combinational path from trace_ready to trace_valid or to trace_* fields.

## Test plan
- Filter: drive wen = 4'hF with wnum = 0, then wen = 0 with wnum = 5, then wen = 4'h1, wnum = 5, pc = 32'hBFC0_0380, wdata = 32'h1234_5678. Required: only the third is stored; level = 1; trace_pc = 32'hBFC0_0380 and trace_wdata = 32'h1234_5678 one cycle later.
- Fill and drop: trace_ready = 0, 18 consecutive commits with wdata = 0..17. Required:
  - level = 16, overflow = 1, drop_cnt = 2.
  - Draining yields wdata 0..15 in order, then trace_valid = 0.
- Full with simultaneous pop: FIFO full, trace_ready = 1, one new commit with wdata = 32'hAA. Required: level stays 16, drop_cnt unchanged, wdata = 32'hAA emerges 16th.
- Streaming with wrap: 40 back-to-back commits, trace_ready = 1 throughout. Required: outputs in order, each one cycle after its capture, level ≤ 1, no drops.
- Backpressure stability: 3 entries stored, toggle trace_ready 0/1 every cycle. Required: trace_* unchanged while ready = 0; the three entries are delivered in order.
- Clear and reset: with 5 entries, drop_cnt = 7 and a concurrent capture, assert clear for one cycle. Required: level = 0, overflow = 0, drop_cnt = 0 next cycle. Then async reset asserted mid-stream (no clock edge) forces trace_valid = 0 immediately.
